// File: rtl/mulq_arbiter.sv
// ---------------------------------------------------------------------------
// mulq_arbiter
// Arbitrates NREQ signed 16-bit operand requesters (round-robin or fixed
// priority, with per-requester masking) into a two-stage pipeline that
// multiplies the winning operand by 3329 and presents a 32-bit signed result
// with the owning requester index. A single stall condition (result held but
// not accepted downstream) freezes the whole pipeline and blocks new grants.
//
// Ports
//   clk        : clock, rising edge
//   srst       : synchronous active-high reset
//   req_valid  : [NREQ]     per-requester operand valid
//   req_data   : [16*NREQ]  operands, requester i at [16i+15:16i]
//   req_ready  : [NREQ]     one-hot grant/accept (combinational)
//   cfg_mode   : 0 round-robin, 1 fixed priority (requester 0 highest)
//   cfg_mask   : [NREQ]     1 excludes requester i from arbitration
//   rsp_valid  : result valid
//   rsp_id     : [clog2(NREQ)] requester owning the result
//   rsp_data   : [32]       operand * 3329, two's complement
//   rsp_ready  : downstream accept
//   busy       : any pipeline stage holds a valid entry
//   op_cnt     : [CNT_W]    accepted-request count, saturating
// ---------------------------------------------------------------------------
module mulq_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [16*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     cfg_mode,
    input  logic [NREQ-1:0]          cfg_mask,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [31:0]              rsp_data,
    input  logic                     rsp_ready,
    output logic                     busy,
    output logic [CNT_W-1:0]         op_cnt
);

    localparam int unsigned ID_W = $clog2(NREQ);

    logic [ID_W-1:0]  r_rr_ptr;
    logic             r_s1_valid;
    logic [15:0]      r_s1_data;
    logic [ID_W-1:0]  r_s1_id;
    logic             r_s2_valid;
    logic [31:0]      r_s2_data;
    logic [ID_W-1:0]  r_s2_id;
    logic [CNT_W-1:0] r_op_cnt;

    logic             w_stall;
    logic [NREQ-1:0]  w_elig;
    logic             w_found;
    logic [ID_W-1:0]  w_sel;
    logic [ID_W:0]    w_idx;
    logic             w_accept;
    logic [15:0]      w_opnd;
    logic [31:0]      w_prod;

    assign w_stall = r_s2_valid & ~rsp_ready;
    assign w_elig  = req_valid & ~cfg_mask;

    // Requester selection. Round-robin scans rr_ptr+1 .. rr_ptr+NREQ with an
    // explicit wrap so non-power-of-two NREQ works without a modulo.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        if (cfg_mode) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!w_found && w_elig[i]) begin
                    w_found = 1'b1;
                    w_sel   = ID_W'(i);
                end
            end
        end else begin
            for (int unsigned k = 1; k <= NREQ; k++) begin
                w_idx = (ID_W+1)'(r_rr_ptr) + (ID_W+1)'(k);
                if (w_idx >= (ID_W+1)'(NREQ))
                    w_idx = w_idx - (ID_W+1)'(NREQ);
                if (!w_found && w_elig[w_idx[ID_W-1:0]]) begin
                    w_found = 1'b1;
                    w_sel   = w_idx[ID_W-1:0];
                end
            end
        end
    end

    // Grant is suppressed during reset so nothing is accepted on a reset edge.
    always_comb begin
        req_ready = '0;
        if (w_found && !w_stall && !srst)
            req_ready[w_sel] = 1'b1;
    end

    assign w_accept = w_found & ~w_stall & ~srst;

    always_comb begin
        w_opnd = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_sel == ID_W'(i))
                w_opnd = req_data[16*i +: 16];
        end
    end

    // 3329 = 13*256 + 1; the signed multiply keeps the exact 32-bit result.
    assign w_prod = $signed(r_s1_data) * 32'sd3329;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_rr_ptr   <= ID_W'(NREQ - 1);
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_id    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_id    <= '0;
            r_op_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_rr_ptr <= w_sel;
                if (r_op_cnt != '1)
                    r_op_cnt <= r_op_cnt + CNT_W'(1);
            end
            if (!w_stall) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_data <= w_opnd;
                    r_s1_id   <= w_sel;
                end
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= w_prod;
                    r_s2_id   <= r_s1_id;
                end
            end
        end
    end

    assign rsp_valid = r_s2_valid;
    assign rsp_id    = r_s2_id;
    assign rsp_data  = r_s2_data;
    assign busy      = r_s1_valid | r_s2_valid;
    assign op_cnt    = r_op_cnt;

endmodule

// File: tb/tb_mulq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mulq_arbiter
// Directed self-checking bench for mulq_arbiter (NREQ=4, CNT_W=4 so that
// counter saturation is reachable quickly). Inputs change 2 time units after
// each rising edge; a small in-order scoreboard sampled on the falling edge
// checks id and product of every delivered result.
// ---------------------------------------------------------------------------
module tb_mulq_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned CNT_W = 4;

    logic               clk = 1'b0;
    logic               srst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [16*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]    req_ready;
    logic               cfg_mode = 1'b0;
    logic [NREQ-1:0]    cfg_mask = '0;
    logic               rsp_valid;
    logic [1:0]         rsp_id;
    logic [31:0]        rsp_data;
    logic               rsp_ready = 1'b1;
    logic               busy;
    logic [CNT_W-1:0]   op_cnt;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    mulq_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .srst      (srst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cfg_mode  (cfg_mode),
        .cfg_mask  (cfg_mask),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] ref_prod(input logic [15:0] d);
        longint v;
        v = longint'($signed(d)) * 64'sd3329;
        return v[31:0];
    endfunction

    // In-order scoreboard: consume delivered result first, then record grant.
    always @(negedge clk) begin
        exp_t e;
        if (srst) begin
            sb_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_id", 32'(rsp_id), 32'(e.id));
                    chk("sb_data", rsp_data, e.data);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id   = 2'(i);
                    e.data = ref_prod(req_data[16*i +: 16]);
                    sb_q.push_back(e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] ext_op  [3];
    logic [31:0] ext_exp [3];
    logic [3:0]  rr_exp  [5];
    logic [3:0]  msk_exp [4];
    logic [31:0] held;
    int          acc;

    initial begin
        ext_op  = '{16'hFFFF, 16'h7FFF, 16'h8000};
        ext_exp = '{32'hFFFFF2FF, 32'h068072FF, 32'hF97F8000};
        rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        msk_exp = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};

        // Reset state, with every requester asking
        srst = 1'b1;
        req_valid = 4'b1111;
        repeat (3) tick();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_cnt", 32'(op_cnt), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);

        // Single operation, latency 2
        srst = 1'b0;
        req_valid = 4'b0001;
        req_data[15:0] = 16'h0001;
        #1;
        chk("single_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = '0;
        chk("single_busy_s1", 32'(busy), 32'd1);
        chk("single_early_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_id", 32'(rsp_id), 32'd0);
        chk("single_data", rsp_data, 32'h00000D01);
        chk("single_op_cnt", 32'(op_cnt), 32'd1);
        tick();
        chk("single_done_valid", 32'(rsp_valid), 32'd0);
        chk("single_done_busy", 32'(busy), 32'd0);

        // Sign and range extremes
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'b0001;
            req_data[15:0] = ext_op[k];
            tick();
            req_valid = '0;
            tick();
            chk("ext_valid", 32'(rsp_valid), 32'd1);
            chk("ext_data", rsp_data, ext_exp[k]);
            tick();
        end
        chk("ext_op_cnt", 32'(op_cnt), 32'd4);

        // Round-robin from reset, all eligible
        srst = 1'b1;
        tick();
        srst = 1'b0;
        req_data = {16'h0444, 16'hF333, 16'h0222, 16'h8111};
        req_valid = 4'b1111;
        cfg_mode = 1'b0;
        cfg_mask = '0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(rr_exp[k]));
            tick();
        end

        // Round-robin with requester 1 masked
        srst = 1'b1;
        tick();
        srst = 1'b0;
        cfg_mask = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_mask_grant", 32'(req_ready), 32'(msk_exp[k]));
            tick();
        end

        // Counter saturation (4 accepted so far since reset)
        cfg_mask = '0;
        repeat (10) tick();
        chk("cnt_14", 32'(op_cnt), 32'd14);
        tick();
        chk("cnt_15", 32'(op_cnt), 32'd15);
        repeat (3) tick();
        chk("cnt_sat", 32'(op_cnt), 32'd15);

        // Fixed priority: 1 always beats 3
        cfg_mode = 1'b1;
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fp_grant", 32'(req_ready), 32'b0010);
            tick();
        end

        // Backpressure with continuous requests
        cfg_mode = 1'b0;
        req_valid = 4'b1111;
        repeat (3) tick();
        chk("bp_full_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b0;
        held = rsp_data;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_no_grant", 32'(req_ready), 32'd0);
            if (req_ready != '0) acc++;
            tick();
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_data", rsp_data, held);
        end
        chk("bp_acc_le2", 32'(acc <= 2), 32'd1);
        rsp_ready = 1'b1;
        repeat (6) tick();
        req_valid = '0;
        repeat (3) tick();
        chk("bp_drain_busy", 32'(busy), 32'd0);
        chk("bp_drain_q", 32'(sb_q.size()), 32'd0);

        // Reset with both stages valid
        req_valid = 4'b1111;
        repeat (3) tick();
        chk("mid_pre_valid", 32'(rsp_valid), 32'd1);
        chk("mid_pre_busy", 32'(busy), 32'd1);
        srst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        tick();
        srst = 1'b0;
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_op_cnt", 32'(op_cnt), 32'd0);
        #1;
        chk("mid_first_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        repeat (3) tick();
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_q", 32'(sb_q.size()), 32'd0);
        chk("end_op_cnt", 32'(op_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
